swap_pair_scheduler: RTL and testbench

//  Owns a pair of WIDTH-bit registers A and B and shares them between two requesters.

---
 rtl/swap_pair_scheduler.sv | 164 ++++++++++++++++
 tb/tb_swap_pair_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/swap_pair_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : swap_pair_scheduler
//  Description : Two-requester, round-robin arbitrated command sequencer that
//                owns registers A and B (read / load / swap-burst) and pulses
//                pop one cycle after either register changes value.
//  Revision    : 1.0 - initial release
// ============================================================================
module swap_pair_scheduler #(
    parameter int               WIDTH  = 8,
    parameter int               CNT_W  = 4,
    parameter logic [WIDTH-1:0] A_INIT = WIDTH'(1),
    parameter logic [WIDTH-1:0] B_INIT = WIDTH'(0)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_cmd,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [CNT_W-1:0] req0_count,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_cmd,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [CNT_W-1:0] req1_count,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             pop
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_EXEC   = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    localparam logic [1:0] c_CMD_READ  = 2'b00;
    localparam logic [1:0] c_CMD_LOADA = 2'b01;
    localparam logic [1:0] c_CMD_LOADB = 2'b10;
    localparam logic [1:0] c_CMD_SWAP  = 2'b11;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_rr_last;
    logic             r_id;
    logic [1:0]       r_cmd;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_pop;

    logic             w_idle;
    logic             w_gnt_id;
    logic             w_handshake;
    logic             w_last_exec;
    logic [1:0]       w_sel_cmd;
    logic [WIDTH-1:0] w_sel_data;
    logic [CNT_W-1:0] w_sel_count;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [CNT_W-1:0] w_cnt_next;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_gnt_id    = (req0_valid && req1_valid) ? ~r_rr_last : req1_valid;
    assign w_handshake = w_idle && (req0_valid || req1_valid);
    assign w_sel_cmd   = w_gnt_id ? req1_cmd   : req0_cmd;
    assign w_sel_data  = w_gnt_id ? req1_data  : req0_data;
    assign w_sel_count = w_gnt_id ? req1_count : req0_count;

    // Swap runs max(count,1) cycles; count 0 or 1 both finish after one cycle.
    assign w_last_exec = (r_cmd != c_CMD_SWAP) || (r_cnt <= CNT_W'(1));

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_handshake) w_state_next = c_ST_EXEC;
            c_ST_EXEC: if (w_last_exec) w_state_next = c_ST_DONE;
            c_ST_DONE: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy       = !w_idle;
        done       = (r_state == c_ST_DONE);
        done_id    = (r_state == c_ST_DONE) && r_id;
        req0_ready = w_idle && req0_valid && !w_gnt_id;
        req1_ready = w_idle && req1_valid &&  w_gnt_id;
    end

    // Command latch and round-robin history
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_last <= 1'b1;
            r_id      <= 1'b0;
            r_cmd     <= c_CMD_READ;
            r_data    <= '0;
        end else if (w_handshake) begin
            r_rr_last <= w_gnt_id;
            r_id      <= w_gnt_id;
            r_cmd     <= w_sel_cmd;
            r_data    <= w_sel_data;
        end
    end

    // Register datapath next values
    always_comb begin
        w_a_next   = r_a;
        w_b_next   = r_b;
        w_cnt_next = r_cnt;
        if (w_handshake) begin
            w_cnt_next = w_sel_count;
        end else if (r_state == c_ST_EXEC) begin
            case (r_cmd)
                c_CMD_LOADA: w_a_next = r_data;
                c_CMD_LOADB: w_b_next = r_data;
                c_CMD_SWAP: begin
                    if (r_cnt != '0) begin
                        w_a_next   = r_b;
                        w_b_next   = r_a;
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registers A/B, burst counter and the change pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= A_INIT;
            r_b   <= B_INIT;
            r_cnt <= '0;
            r_pop <= 1'b0;
        end else begin
            r_a   <= w_a_next;
            r_b   <= w_b_next;
            r_cnt <= w_cnt_next;
            r_pop <= (w_a_next != r_a) || (w_b_next != r_b);
        end
    end

    assign a_out = r_a;
    assign b_out = r_b;
    assign pop   = r_pop;

endmodule
`default_nettype wire

// File: tb/tb_swap_pair_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_swap_pair_scheduler
//  Description : Directed, table-driven bench for swap_pair_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_swap_pair_scheduler;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_cmd, req1_cmd;
    logic [7:0] req0_data, req1_data;
    logic [3:0] req0_count, req1_count;
    logic [7:0] a_out, b_out;
    logic       busy, done, done_id, pop;

    int n_total  = 0;
    int n_passed = 0;

    always #5 clock = ~clock;

    swap_pair_scheduler #(.WIDTH(8), .CNT_W(4), .A_INIT(8'h01), .B_INIT(8'h00)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_cmd   (req0_cmd),
        .req0_data  (req0_data),
        .req0_count (req0_count),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_cmd   (req1_cmd),
        .req1_data  (req1_data),
        .req1_count (req1_count),
        .a_out      (a_out),
        .b_out      (b_out),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .pop        (pop)
    );

    typedef struct {
        bit         id;
        logic [1:0] cmd;
        logic [7:0] data;
        logic [3:0] cnt;
        logic [7:0] ea;
        logic [7:0] eb;
        int         epops;
        int         elat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic set_req(input bit id, input logic v, input logic [1:0] c,
                           input logic [7:0] d, input logic [3:0] n);
        if (id) begin
            req1_valid = v; req1_cmd = c; req1_data = d; req1_count = n;
        end else begin
            req0_valid = v; req0_cmd = c; req0_data = d; req0_count = n;
        end
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic run_cmd(input bit id, input logic [1:0] c, input logic [7:0] d,
                           input logic [3:0] n, output int lat, output int pops,
                           output bit did, output bit ok);
        int w;
        int k;
        ok = 1'b1; lat = 0; pops = 0; did = 1'b0;
        set_req(id, 1'b1, c, d, n);
        #1;
        w = 0;
        while (!(id ? req1_ready : req0_ready) && w < 50) begin
            @(negedge clock); #1; w++;
        end
        if (w >= 50) begin
            check("ready_timeout", 32'(w), 32'd0);
            set_req(id, 1'b0, 2'b00, 8'h00, 4'h0);
            ok = 1'b0;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        set_req(id, 1'b0, 2'b00, 8'h00, 4'h0);
        #1;
        k = 1;
        while (1) begin
            pops += int'(pop);
            if (done) begin
                lat = k; did = done_id;
                break;
            end
            if (k >= 40) begin
                check("done_timeout", 32'(k), 32'd0);
                ok = 1'b0;
                return;
            end
            @(negedge clock); #1; k++;
        end
        @(negedge clock); #1;
        pops += int'(pop);
    endtask

    initial begin
        int  lat, pops, grants, gap, cyc, ndone, npop;
        bit  did, ok, exp_gnt;

        reset_n = 1'b0;
        set_req(1'b0, 1'b0, 2'b00, 8'h00, 4'h0);
        set_req(1'b1, 1'b0, 2'b00, 8'h00, 4'h0);

        //           id  cmd    data   cnt   A      B      pops lat
        vecs[0]  = '{1'b0, 2'b01, 8'h5A, 4'd0,  8'h5A, 8'h00, 1,  2};
        vecs[1]  = '{1'b1, 2'b10, 8'hC3, 4'd0,  8'h5A, 8'hC3, 1,  2};
        vecs[2]  = '{1'b0, 2'b11, 8'h00, 4'd3,  8'hC3, 8'h5A, 3,  4};
        vecs[3]  = '{1'b1, 2'b11, 8'h00, 4'd2,  8'hC3, 8'h5A, 2,  3};
        vecs[4]  = '{1'b0, 2'b11, 8'h00, 4'd0,  8'hC3, 8'h5A, 0,  2};
        vecs[5]  = '{1'b1, 2'b00, 8'hFF, 4'd7,  8'hC3, 8'h5A, 0,  2};
        vecs[6]  = '{1'b0, 2'b01, 8'h5A, 4'd0,  8'h5A, 8'h5A, 1,  2};
        vecs[7]  = '{1'b1, 2'b11, 8'h00, 4'd1,  8'h5A, 8'h5A, 0,  2};
        vecs[8]  = '{1'b0, 2'b10, 8'h5A, 4'd0,  8'h5A, 8'h5A, 0,  2};
        vecs[9]  = '{1'b1, 2'b10, 8'h00, 4'd0,  8'h5A, 8'h00, 1,  2};
        vecs[10] = '{1'b0, 2'b11, 8'h00, 4'd15, 8'h00, 8'h5A, 15, 16};

        // Reset and idle
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("rst_a",    32'(a_out), 32'h01);
        check("rst_b",    32'(b_out), 32'h00);
        check("rst_busy", 32'(busy),  32'd0);
        check("rst_done", 32'(done),  32'd0);
        check("rst_pop",  32'(pop),   32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);

        // Both requesters valid continuously: grants alternate 0,1,0,1
        @(negedge clock);
        set_req(1'b0, 1'b1, 2'b00, 8'h00, 4'h0);
        set_req(1'b1, 1'b1, 2'b00, 8'h00, 4'h0);
        #1;
        grants = 0; gap = 0; cyc = 0; exp_gnt = 1'b0;
        while (grants < 4 && cyc < 100) begin
            if (req0_ready || req1_ready) begin
                check("arb_grant", 32'(req1_ready), 32'(exp_gnt));
                check("arb_loser_ready", 32'(exp_gnt ? req0_ready : req1_ready), 32'd0);
                if (grants > 0) check("arb_gap", 32'(gap), 32'd3);
                grants++; gap = 0; exp_gnt = ~exp_gnt;
            end
            @(negedge clock); #1; gap++; cyc++;
            if (grants == 4) begin
                set_req(1'b0, 1'b0, 2'b00, 8'h00, 4'h0);
                set_req(1'b1, 1'b0, 2'b00, 8'h00, 4'h0);
            end
        end
        check("arb_grant_count", 32'(grants), 32'd4);
        cyc = 0;
        while (busy && cyc < 10) begin @(negedge clock); #1; cyc++; end
        @(negedge clock);

        // Table-driven commands
        foreach (vecs[i]) begin
            run_cmd(vecs[i].id, vecs[i].cmd, vecs[i].data, vecs[i].cnt, lat, pops, did, ok);
            if (ok) begin
                check($sformatf("v%0d_a", i),       32'(a_out), 32'(vecs[i].ea));
                check($sformatf("v%0d_b", i),       32'(b_out), 32'(vecs[i].eb));
                check($sformatf("v%0d_pops", i),    32'(pops),  32'(vecs[i].epops));
                check($sformatf("v%0d_latency", i), 32'(lat),   32'(vecs[i].elat));
                check($sformatf("v%0d_done_id", i), 32'(did),   32'(vecs[i].id));
            end
        end

        // Reset in the middle of a 15-exchange burst (A=00, B=5A beforehand)
        set_req(1'b0, 1'b1, 2'b11, 8'h00, 4'd15);
        @(posedge clock);
        @(negedge clock);
        set_req(1'b0, 1'b0, 2'b00, 8'h00, 4'h0);
        repeat (4) @(negedge clock);
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_a",    32'(a_out), 32'h01);
        check("mid_rst_b",    32'(b_out), 32'h00);
        check("mid_rst_busy", 32'(busy),  32'd0);
        check("mid_rst_done", 32'(done),  32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        ndone = 0; npop = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock); #1;
            ndone += int'(done);
            npop  += int'(pop);
        end
        check("post_rst_no_done", 32'(ndone), 32'd0);
        check("post_rst_no_pop",  32'(npop),  32'd0);
        check("post_rst_a",       32'(a_out), 32'h01);
        @(negedge clock);
        run_cmd(1'b1, 2'b01, 8'h77, 4'd0, lat, pops, did, ok);
        if (ok) begin
            check("post_rst_cmd_a",   32'(a_out), 32'h77);
            check("post_rst_cmd_b",   32'(b_out), 32'h00);
            check("post_rst_cmd_pop", 32'(pops),  32'd1);
            check("post_rst_cmd_lat", 32'(lat),   32'd2);
            check("post_rst_cmd_id",  32'(did),   32'd1);
        end

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
`default_nettype wire
